// File: rtl/id1_stage_ctrl_if.sv
// ID1->EX1 boundary bundle: ID1/EX1 status into the stage controller, ACT/hold/kill back out.
// Latency: none; this is a pure signal grouping.
// Backpressure: carried by ex1_busy (EX1 refuses) and id1_stall (ID1 holds).
interface id1_stage_ctrl_if;
  // Decoded instruction sitting in ID1
  logic       id1_valid;
  logic [4:0] id1_rs1;
  logic [4:0] id1_rs2;
  logic       id1_use_rs1;
  logic       id1_use_rs2;
  // Instruction currently occupying EX1
  logic       ex1_valid;
  logic [4:0] ex1_rd;
  logic       ex1_is_load;
  logic       ex1_busy;
  // Redirect from branch/exception resolution
  logic       flush;
  // Controls produced by the stage controller
  logic       id1_act;
  logic       ex1_valid_o;
  logic       id1_stall;
  logic       id1_kill;

  // Pipeline side: supplies status, consumes controls
  modport master (
    output id1_valid, id1_rs1, id1_rs2, id1_use_rs1, id1_use_rs2,
    output ex1_valid, ex1_rd, ex1_is_load, ex1_busy, flush,
    input  id1_act, ex1_valid_o, id1_stall, id1_kill
  );

  // Controller side
  modport slave (
    input  id1_valid, id1_rs1, id1_rs2, id1_use_rs1, id1_use_rs2,
    input  ex1_valid, ex1_rd, ex1_is_load, ex1_busy, flush,
    output id1_act, ex1_valid_o, id1_stall, id1_kill
  );
endinterface

// File: rtl/id1_stage_ctrl.sv
// ID1->EX1 stage controller: ACT strobe, EX1 valid, ID1 hold/kill; sequences load-use bubbles,
// EX1 back-pressure holds and redirect squashes. Outputs are Mealy (0 cycles); state registered.
// Backpressure: ex1_busy drops ACT and holds ID1; flush overrides busy. Optional perf counters
// are built when ID1_PERF_CNT_EN is defined.
module id1_stage_ctrl #(
  parameter int LU_LATENCY   = 1,   // bubbles per load-use hazard (1..7)
  parameter int FLUSH_CYCLES = 1    // cycles ID1 is killed after a redirect (1..7)
`ifdef ID1_PERF_CNT_EN
  , parameter int CNT_W      = 32   // perf counter width
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  id1_stage_ctrl_if.slave      bus
`ifdef ID1_PERF_CNT_EN
  , input  logic               perf_clr,
  output logic [CNT_W-1:0]     perf_stall,
  output logic [CNT_W-1:0]     perf_bubble
`endif
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_LU    = 2'd1,
    S_HOLD  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  // The first bubble is issued from RUN, so LU only needs LU_LATENCY-1 more cycles.
  localparam logic [2:0] LU_RELOAD = (LU_LATENCY > 1) ? 3'(LU_LATENCY - 2) : 3'd0;
  // The redirect cycle itself kills once; FLUSH covers the remaining FLUSH_CYCLES-1.
  localparam logic [2:0] FL_RELOAD = (FLUSH_CYCLES > 1) ? 3'(FLUSH_CYCLES - 1) : 3'd0;

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       haz;
  logic       act, vld_o, stall, kill;

  // Load-use hazard: ID1 reads a non-zero register that the load in EX1 has not produced yet
  always_comb begin
    haz = bus.id1_valid & bus.ex1_valid & bus.ex1_is_load & (bus.ex1_rd != 5'd0) &
          ((bus.id1_use_rs1 & (bus.id1_rs1 == bus.ex1_rd)) |
           (bus.id1_use_rs2 & (bus.id1_rs2 == bus.ex1_rd)));
  end

  // Next-state and Mealy outputs; priority flush > busy > state action > hazard > issue
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    act       = 1'b1;
    vld_o     = 1'b0;
    stall     = 1'b0;
    kill      = 1'b0;

    if (bus.flush) begin
      // Squash ID1; ACT stays high so EX1 captures a bubble even if it reports busy
      kill      = 1'b1;
      cnt_nxt   = FL_RELOAD;
      state_nxt = (FLUSH_CYCLES > 1) ? S_FLUSH : S_RUN;
    end else if (bus.ex1_busy) begin
      // EX1 cannot take anything: hold ID1, freeze cnt, drop any pending LU/FLUSH work
      act       = 1'b0;
      stall     = 1'b1;
      state_nxt = S_HOLD;
    end else begin
      unique case (state)
        S_LU: begin
          // Keep feeding bubbles until the load result is forwardable
          stall = 1'b1;
          if (cnt == 3'd0) state_nxt = S_RUN;
          else             cnt_nxt   = cnt - 3'd1;
        end
        S_FLUSH: begin
          // cnt holds the number of FLUSH cycles still owed, this one included
          kill = 1'b1;
          if (cnt != 3'd0) cnt_nxt = cnt - 3'd1;
          if (cnt <= 3'd1) state_nxt = S_RUN;
        end
        default: begin
          // RUN, and HOLD once busy clears: ordinary issue or a fresh hazard bubble
          state_nxt = S_RUN;
          if (haz) begin
            stall = 1'b1;
            if (LU_LATENCY > 1) begin
              state_nxt = S_LU;
              cnt_nxt   = LU_RELOAD;
            end
          end else begin
            vld_o = bus.id1_valid;
          end
        end
      endcase
    end

    // While reset is asserted the outputs are forced regardless of state
    if (!rst_n) begin
      act   = 1'b0;
      vld_o = 1'b0;
      stall = 1'b0;
      kill  = 1'b1;
    end
  end

  // State and sequencing counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RUN;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Drive controls onto the bundle
  always_comb begin
    bus.id1_act     = act;
    bus.ex1_valid_o = vld_o;
    bus.id1_stall   = stall;
    bus.id1_kill    = kill;
  end

`ifdef ID1_PERF_CNT_EN
  logic bubble_evt;

  // A bubble is an ACT that writes an invalid entry for any reason other than a redirect
  always_comb begin
    bubble_evt = act & ~vld_o & ~bus.flush;
  end

  // Saturating perf counters; clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall  <= '0;
      perf_bubble <= '0;
    end else if (perf_clr) begin
      perf_stall  <= '0;
      perf_bubble <= '0;
    end else begin
      if (stall && (perf_stall != '1))
        perf_stall <= perf_stall + 1'b1;
      if (bubble_evt && (perf_bubble != '1))
        perf_bubble <= perf_bubble + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_id1_stage_ctrl.sv
// Directed bench for id1_stage_ctrl: instance a (LU_LATENCY=1, FLUSH_CYCLES=1) and
// instance b (LU_LATENCY=3, FLUSH_CYCLES=2) see identical stimulus.
// Outputs are sampled 1ns after the falling edge where inputs change.
module tb_id1_stage_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       id1_valid, id1_use_rs1, id1_use_rs2;
  logic [4:0] id1_rs1, id1_rs2, ex1_rd;
  logic       ex1_valid, ex1_is_load, ex1_busy, flush;

  id1_stage_ctrl_if bus_a ();
  id1_stage_ctrl_if bus_b ();

  assign bus_a.id1_valid   = id1_valid;    assign bus_b.id1_valid   = id1_valid;
  assign bus_a.id1_rs1     = id1_rs1;      assign bus_b.id1_rs1     = id1_rs1;
  assign bus_a.id1_rs2     = id1_rs2;      assign bus_b.id1_rs2     = id1_rs2;
  assign bus_a.id1_use_rs1 = id1_use_rs1;  assign bus_b.id1_use_rs1 = id1_use_rs1;
  assign bus_a.id1_use_rs2 = id1_use_rs2;  assign bus_b.id1_use_rs2 = id1_use_rs2;
  assign bus_a.ex1_valid   = ex1_valid;    assign bus_b.ex1_valid   = ex1_valid;
  assign bus_a.ex1_rd      = ex1_rd;       assign bus_b.ex1_rd      = ex1_rd;
  assign bus_a.ex1_is_load = ex1_is_load;  assign bus_b.ex1_is_load = ex1_is_load;
  assign bus_a.ex1_busy    = ex1_busy;     assign bus_b.ex1_busy    = ex1_busy;
  assign bus_a.flush       = flush;        assign bus_b.flush       = flush;

`ifdef ID1_PERF_CNT_EN
  logic       perf_clr;
  logic [3:0] perf_stall_a, perf_bubble_a, perf_stall_b, perf_bubble_b;
`endif

  id1_stage_ctrl #(
    .LU_LATENCY(1), .FLUSH_CYCLES(1)
`ifdef ID1_PERF_CNT_EN
    , .CNT_W(4)
`endif
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave)
`ifdef ID1_PERF_CNT_EN
    , .perf_clr(perf_clr), .perf_stall(perf_stall_a), .perf_bubble(perf_bubble_a)
`endif
  );

  id1_stage_ctrl #(
    .LU_LATENCY(3), .FLUSH_CYCLES(2)
`ifdef ID1_PERF_CNT_EN
    , .CNT_W(4)
`endif
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave)
`ifdef ID1_PERF_CNT_EN
    , .perf_clr(perf_clr), .perf_stall(perf_stall_b), .perf_bubble(perf_bubble_b)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Packed {act, ex1_valid_o, stall, kill}
  function automatic logic [3:0] oa();
    return {bus_a.id1_act, bus_a.ex1_valid_o, bus_a.id1_stall, bus_a.id1_kill};
  endfunction
  function automatic logic [3:0] ob();
    return {bus_b.id1_act, bus_b.ex1_valid_o, bus_b.id1_stall, bus_b.id1_kill};
  endfunction

  localparam logic [3:0] O_RST    = 4'b0001;
  localparam logic [3:0] O_ISSUE  = 4'b1100;
  localparam logic [3:0] O_EMPTY  = 4'b1000;
  localparam logic [3:0] O_BUBBLE = 4'b1010;
  localparam logic [3:0] O_BUSY   = 4'b0010;
  localparam logic [3:0] O_FLUSH  = 4'b1001;

  task automatic idle();
    id1_valid = 1'b0; id1_rs1 = 5'd0; id1_rs2 = 5'd0;
    id1_use_rs1 = 1'b0; id1_use_rs2 = 1'b0;
    ex1_valid = 1'b0; ex1_rd = 5'd0; ex1_is_load = 1'b0;
    ex1_busy = 1'b0; flush = 1'b0;
  endtask

  // EX1 holds a load to rd; ID1 reads it through rs1
  task automatic load_use(input logic [4:0] rd);
    id1_valid = 1'b1; ex1_valid = 1'b1; ex1_is_load = 1'b1; ex1_rd = rd;
    id1_rs1 = rd; id1_use_rs1 = 1'b1; id1_rs2 = 5'd0; id1_use_rs2 = 1'b0;
  endtask

  int nb;

  initial begin
    rst_n = 1'b0;
    idle();
`ifdef ID1_PERF_CNT_EN
    perf_clr = 1'b0;
`endif
    #2;
    chk("rst_a", oa(), O_RST);
    chk("rst_b", ob(), O_RST);

    @(negedge clk); rst_n = 1'b1; id1_valid = 1'b1; #1;
    chk("rel_a", oa(), O_ISSUE);
    chk("rel_b", ob(), O_ISSUE);

    @(negedge clk); id1_valid = 1'b0; #1;
    chk("empty_a", oa(), O_EMPTY);

    // Load-use on rs1=5: a bubbles once, b three times
    @(negedge clk); load_use(5'd5); #1;
    chk("lu_c0_a", oa(), O_BUBBLE);
    chk("lu_c0_b", ob(), O_BUBBLE);
    @(negedge clk); ex1_valid = 1'b0; #1;
    chk("lu_c1_a", oa(), O_ISSUE);
    chk("lu_c1_b", ob(), O_BUBBLE);
    @(negedge clk); #1;
    chk("lu_c2_b", ob(), O_BUBBLE);
    @(negedge clk); #1;
    chk("lu_c3_b", ob(), O_ISSUE);

    // Hazard through rs2=7 only: count b bubbles over five cycles
    @(negedge clk);
    idle(); id1_valid = 1'b1; ex1_valid = 1'b1; ex1_is_load = 1'b1; ex1_rd = 5'd7;
    id1_rs1 = 5'd3; id1_use_rs1 = 1'b1; id1_rs2 = 5'd7; id1_use_rs2 = 1'b1;
    nb = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (i == 0) chk("lu_rs2_a", oa(), O_BUBBLE);
      if (ob() == O_BUBBLE) nb++;
      @(negedge clk); ex1_valid = 1'b0;
    end
    #1;
    chk("lu3_count", nb, 3);
    chk("lu3_issue_b", ob(), O_ISSUE);

    // rd=0 never hazards
    @(negedge clk); load_use(5'd0); #1;
    chk("rd0_a", oa(), O_ISSUE);
    chk("rd0_b", ob(), O_ISSUE);

    // Async reset in the middle of a load-use sequence
    @(negedge clk); load_use(5'd5); #1;
    chk("rlu_c0_b", ob(), O_BUBBLE);
    @(negedge clk); ex1_valid = 1'b0; #1;
    chk("rlu_c1_b", ob(), O_BUBBLE);
    #2; rst_n = 1'b0; #1;
    chk("rst_async_b", ob(), O_RST);
    chk("rst_async_a", oa(), O_RST);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rst_run_b", ob(), O_ISSUE);

    // EX1 busy for four cycles, then release
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); ex1_busy = 1'b1; #1;
      chk("busy_a", oa(), O_BUSY);
    end
    @(negedge clk); ex1_busy = 1'b0; #1;
    chk("hold_exit_a", oa(), O_ISSUE);

    // Flush wins over busy
    @(negedge clk); ex1_busy = 1'b1; flush = 1'b1; #1;
    chk("busyfl_a", oa(), O_FLUSH);
    chk("busyfl_b", ob(), O_FLUSH);
    @(negedge clk); ex1_busy = 1'b0; flush = 1'b0; #1;
    chk("busyfl_n_a", oa(), O_ISSUE);
    chk("busyfl_n_b", ob(), O_FLUSH);
    @(negedge clk); #1;
    chk("busyfl_nn_b", ob(), O_ISSUE);

    // Back-to-back flush pulses at t0,t1: b kills through t2
    @(negedge clk); flush = 1'b1; #1;
    chk("fl_t0_b", ob(), O_FLUSH);
    @(negedge clk); #1;
    chk("fl_t1_b", ob(), O_FLUSH);
    @(negedge clk); flush = 1'b0; #1;
    chk("fl_t2_b", ob(), O_FLUSH);
    chk("fl_t2_a", oa(), O_ISSUE);
    @(negedge clk); #1;
    chk("fl_t3_b", ob(), O_ISSUE);

    // Busy during LU drops the remaining bubbles
    @(negedge clk); load_use(5'd9); #1;
    chk("lulost_c0_b", ob(), O_BUBBLE);
    @(negedge clk); ex1_valid = 1'b0; ex1_busy = 1'b1; #1;
    chk("lulost_c1_b", ob(), O_BUSY);
    @(negedge clk); ex1_busy = 1'b0; #1;
    chk("lulost_c2_b", ob(), O_ISSUE);

`ifdef ID1_PERF_CNT_EN
    @(negedge clk); idle(); perf_clr = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); perf_clr = 1'b0; ex1_busy = 1'b1;
    end
    @(negedge clk); ex1_busy = 1'b0; id1_valid = 1'b1; #1;
    chk("perf_stall_sat", perf_stall_a, 15);
    chk("perf_bubble_0", perf_bubble_a, 0);
    @(negedge clk); perf_clr = 1'b1;
    @(negedge clk); perf_clr = 1'b0; #1;
    chk("perf_stall_clr", perf_stall_a, 0);
    @(negedge clk); load_use(5'd5);
    @(negedge clk); ex1_valid = 1'b0; #1;
    chk("perf_bubble_1", perf_bubble_a, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
